// File: rtl/boreal_ledger_pkg.sv
// -----------------------------------------------------------------------------
// boreal_ledger_pkg
// Shared definitions for the append-only event ledger:
//   - event_t           : 256-bit event payload, word k = bits [32k+31:32k]
//   - LED_REG_*         : MMIO word addresses (reads and write commands)
//   - fold_event()      : XOR of the eight payload words
//   - chain_next()      : one step of the running CHAIN digest
// -----------------------------------------------------------------------------
package boreal_ledger_pkg;

  localparam int EV_WORDS = 8;
  localparam int EV_W     = 32 * EV_WORDS;

  typedef logic [EV_W-1:0] event_t;

  // Read-side registers
  localparam logic [7:0] LED_REG_STATUS = 8'h00;
  localparam logic [7:0] LED_REG_SEQ    = 8'h01;
  localparam logic [7:0] LED_REG_DROPS  = 8'h02;
  localparam logic [7:0] LED_REG_CHAIN  = 8'h03;
  localparam logic [7:0] LED_REG_HEAD0  = 8'h08;  // 0x08..0x0F: head words 0..7

  // Write-side commands
  localparam logic [7:0] LED_REG_POP    = 8'h10;
  localparam logic [7:0] LED_REG_OVFCLR = 8'h11;
  localparam logic [7:0] LED_REG_SEED   = 8'h12;

  function automatic logic [31:0] fold_event(input event_t ev);
    logic [31:0] acc;
    acc = '0;
    for (int k = 0; k < EV_WORDS; k++) acc ^= ev[32*k +: 32];
    return acc;
  endfunction

  // CHAIN' = rotl(CHAIN, 5) ^ fold(payload) ^ SEQ (value before increment)
  function automatic logic [31:0] chain_next(input logic [31:0] chain,
                                             input event_t      ev,
                                             input logic [31:0] seq);
    return {chain[26:0], chain[31:27]} ^ fold_event(ev) ^ seq;
  endfunction

endpackage

// File: rtl/boreal_ledger_if.sv
// -----------------------------------------------------------------------------
// boreal_ledger_if
// Bundles the gate append port and the MMIO port of the ledger.
//   led_wr/led_event                : append strobe + 256-bit payload
//   mmio_we/mmio_addr/mmio_wdata    : MMIO write strobe, word address, data
//   mmio_rdata                      : registered MMIO read data
//   led_full/led_irq                : FIFO full flag, sticky overflow
// master = gate/CPU side, slave = ledger.
// -----------------------------------------------------------------------------
interface boreal_ledger_if;
  import boreal_ledger_pkg::*;

  logic        led_wr;
  event_t      led_event;
  logic        mmio_we;
  logic [7:0]  mmio_addr;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;
  logic        led_full;
  logic        led_irq;

  modport master (
    output led_wr, led_event, mmio_we, mmio_addr, mmio_wdata,
    input  mmio_rdata, led_full, led_irq
  );

  modport slave (
    input  led_wr, led_event, mmio_we, mmio_addr, mmio_wdata,
    output mmio_rdata, led_full, led_irq
  );

endinterface

// File: rtl/boreal_ledger_fifo.sv
// -----------------------------------------------------------------------------
// boreal_ledger_fifo
// Single-clock FIFO holding accepted ledger events.
//   clk, rst_n : clock, synchronous active-low reset
//   push_i     : write wdata_i (honoured when not full, or full with a pop)
//   pop_i      : drop the head entry (ignored when empty)
//   wdata_i    : entry to append
//   head_o     : oldest entry (undefined contents when empty)
//   full_o     : registered count == DEPTH
//   empty_o    : count == 0
//   count_o    : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module boreal_ledger_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int            AW      = $clog2(DEPTH);
  localparam int            CW      = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push_i && (!full_q || do_pop);

  // NOTE: every signal assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
    full_d = (count_d == DEPTH_C);
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // NOTE: storage is deliberately not reset; count == 0 makes stale
  // contents invisible, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/boreal_ledger.sv
// -----------------------------------------------------------------------------
// boreal_ledger
// Append-only event ledger: events from the gate are sequenced, folded into a
// running CHAIN digest and queued for software, which drains them over MMIO.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : boreal_ledger_if.slave
//                led_wr/led_event in, mmio_we/addr/wdata in,
//                mmio_rdata out (one cycle after addr), led_full, led_irq out
// Parameter DEPTH: FIFO entries, power of two in 2..64.
// -----------------------------------------------------------------------------
module boreal_ledger
  import boreal_ledger_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  boreal_ledger_if.slave bus
);

  localparam int CW = $clog2(DEPTH+1);

  logic          pop_req, pop_ok, accept, drop, ovf_clr, seed_we;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  event_t        fifo_head;

  logic [31:0]   seq_q, seq_d;
  logic [31:0]   drops_q, drops_d;
  logic [31:0]   chain_q, chain_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ovf_q, ovf_d;

  // MMIO write commands
  assign pop_req = bus.mmio_we && (bus.mmio_addr == LED_REG_POP);
  assign ovf_clr = bus.mmio_we && (bus.mmio_addr == LED_REG_OVFCLR) && bus.mmio_wdata[0];
  assign seed_we = bus.mmio_we && (bus.mmio_addr == LED_REG_SEED);

  // Same acceptance rule as the FIFO applies internally, needed here for
  // SEQ/CHAIN/DROPS bookkeeping.
  assign pop_ok = pop_req && !fifo_empty;
  assign accept = bus.led_wr && (!fifo_full || pop_ok);
  assign drop   = bus.led_wr && !accept;

  boreal_ledger_fifo #(
    .WIDTH (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .pop_i   (pop_ok),
    .wdata_i (bus.led_event),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    seq_d   = seq_q;
    drops_d = drops_q;
    chain_d = chain_q;
    ovf_d   = ovf_q;

    // An accepted append owns CHAIN this cycle; a coincident seed is lost.
    if (accept) begin
      seq_d   = seq_q + 32'd1;
      chain_d = chain_next(chain_q, bus.led_event, seq_q);
    end else if (seed_we) begin
      chain_d = bus.mmio_wdata;
    end

    // A drop in the same cycle as W1C keeps the overflow flag set.
    if (drop) begin
      ovf_d = 1'b1;
      if (drops_q != 32'hFFFF_FFFF) drops_d = drops_q + 32'd1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Read decode works on pre-edge state; the result is registered.
  always_comb begin
    rdata_d = '0;
    case (bus.mmio_addr)
      LED_REG_STATUS: rdata_d = {21'h0, ovf_q, fifo_empty, fifo_full, 1'b0, 7'(fifo_count)};
      LED_REG_SEQ:    rdata_d = seq_q;
      LED_REG_DROPS:  rdata_d = drops_q;
      LED_REG_CHAIN:  rdata_d = chain_q;
      default: begin
        if ((bus.mmio_addr[7:3] == LED_REG_HEAD0[7:3]) && !fifo_empty)
          rdata_d = fifo_head[{bus.mmio_addr[2:0], 5'd0} +: 32];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_q   <= '0;
      drops_q <= '0;
      chain_q <= '0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      seq_q   <= seq_d;
      drops_q <= drops_d;
      chain_q <= chain_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.mmio_rdata = rdata_q;
  assign bus.led_full   = fifo_full;
  assign bus.led_irq    = ovf_q;

endmodule

// File: tb/tb_boreal_ledger.sv
// -----------------------------------------------------------------------------
// tb_boreal_ledger
// Self-checking bench for boreal_ledger (DEPTH = 16): a table of directed
// single-cycle vectors, hand-written multi-cycle corner sequences, and a
// randomized run compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_boreal_ledger;
  import boreal_ledger_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  boreal_ledger_if bus ();

  boreal_ledger #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cycle(input logic wr, input event_t ev, input logic we,
                       input logic [7:0] addr, input logic [31:0] wdata);
    bus.led_wr     = wr;
    bus.led_event  = ev;
    bus.mmio_we    = we;
    bus.mmio_addr  = addr;
    bus.mmio_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [31:0] exp, input string name);
    cycle(1'b0, '0, 1'b0, addr, 32'h0);
    check(name, bus.mmio_rdata, exp);
  endtask

  // Reset for two cycles with optional append/seed traffic during reset.
  task automatic do_reset(input logic busy);
    rst_n = 1'b0;
    cycle(busy, {EV_WORDS{32'hA5A5_0001}}, busy, LED_REG_SEED, 32'h1234_5678);
    cycle(busy, {EV_WORDS{32'hA5A5_0002}}, busy, LED_REG_SEED, 32'h1234_5678);
    check("reset rdata", bus.mmio_rdata, 32'h0);
    check("reset full",  {31'h0, bus.led_full}, 32'h0);
    check("reset irq",   {31'h0, bus.led_irq}, 32'h0);
    rst_n = 1'b1;
  endtask

  function automatic event_t mk_ev(input int i);
    event_t e;
    for (int k = 0; k < EV_WORDS; k++) e[32*k +: 32] = 32'(i * 8 + k + 1);
    return e;
  endfunction

  // ---------------- reference model ----------------
  event_t      m_q[$];
  logic [31:0] m_seq, m_drops, m_chain;
  logic        m_ovf;

  function automatic logic [31:0] m_rotl5(input logic [31:0] c);
    return (c << 5) | (c >> 27);
  endfunction

  function automatic logic [31:0] m_fold(input event_t e);
    logic [31:0] f;
    f = 32'h0;
    for (int k = 0; k < EV_WORDS; k++) f = f ^ e[32*k +: 32];
    return f;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    event_t h;
    int     n;
    n = m_q.size();
    if (a == 8'h00) return {21'h0, m_ovf, n == 0, n == DEPTH, 1'b0, 7'(n)};
    if (a == 8'h01) return m_seq;
    if (a == 8'h02) return m_drops;
    if (a == 8'h03) return m_chain;
    if (a >= 8'h08 && a <= 8'h0F && n > 0) begin
      h = m_q[0];
      return h[32*int'(a - 8'h08) +: 32];
    end
    return 32'h0;
  endfunction

  task automatic m_step(input logic wr, input event_t ev, input logic we,
                        input logic [7:0] a, input logic [31:0] wd);
    bit pop_ok, acc;
    pop_ok = we && a == 8'h10 && m_q.size() > 0;
    acc    = wr && (m_q.size() < DEPTH || pop_ok);
    if (acc) begin
      m_chain = m_rotl5(m_chain) ^ m_fold(ev) ^ m_seq;
      m_seq   = m_seq + 1;
    end else if (we && a == 8'h12) begin
      m_chain = wd;
    end
    if (wr && !acc) begin
      m_ovf = 1'b1;
      if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 1;
    end else if (we && a == 8'h11 && wd[0]) begin
      m_ovf = 1'b0;
    end
    if (pop_ok) void'(m_q.pop_front());
    if (acc) m_q.push_back(ev);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        wr;
    logic [31:0] w0;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_full;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[14];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    logic        wr, we;
    logic [7:0]  addr;
    logic [31:0] wdata, exp_rd;
    event_t      ev;
    bit          push_heavy;

    bus.led_wr = 1'b0; bus.led_event = '0; bus.mmio_we = 1'b0;
    bus.mmio_addr = 8'h0; bus.mmio_wdata = 32'h0;

    //            wr  w0     we  addr   wdata  rdata  full irq
    vecs[0]  = '{1'b0, 32'h0, 1'b0, 8'h00, 32'h0, 32'h200, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h1, 1'b0, 8'h01, 32'h0, 32'h0,   1'b0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0, 1'b0, 8'h01, 32'h0, 32'h1,   1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0, 1'b0, 8'h03, 32'h0, 32'h1,   1'b0, 1'b0};
    vecs[4]  = '{1'b0, 32'h0, 1'b0, 8'h00, 32'h0, 32'h001, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'h1, 1'b0, 8'h08, 32'h0, 32'h1,   1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'h0, 1'b0, 8'h03, 32'h0, 32'h20,  1'b0, 1'b0};
    vecs[7]  = '{1'b0, 32'h0, 1'b0, 8'h01, 32'h0, 32'h2,   1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'h0, 1'b0, 8'h09, 32'h0, 32'h0,   1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0, 1'b0, 8'h20, 32'h0, 32'h0,   1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'h0, 1'b0, 8'h00, 32'h0, 32'h002, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'h0, 1'b1, 8'h10, 32'h0, 32'h0,   1'b0, 1'b0};
    vecs[12] = '{1'b0, 32'h0, 1'b0, 8'h00, 32'h0, 32'h001, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 32'h0, 1'b1, 8'h11, 32'h1, 32'h0,   1'b0, 1'b0};

    do_reset(1'b0);
    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].wr, {224'h0, vecs[i].w0}, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d rdata", i), bus.mmio_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d full", i),  {31'h0, bus.led_full}, {31'h0, vecs[i].exp_full});
      check($sformatf("vec%0d irq", i),   {31'h0, bus.led_irq},  {31'h0, vecs[i].exp_irq});
    end

    // ---- fill to DEPTH, overflow, W1C priority, push+pop when full ----
    do_reset(1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, mk_ev(i), 1'b0, 8'h00, 32'h0);
    check("fill full", {31'h0, bus.led_full}, 32'h1);
    check("fill irq",  {31'h0, bus.led_irq}, 32'h0);
    rd(8'h00, 32'h110, "fill status");
    cycle(1'b1, mk_ev(DEPTH), 1'b0, 8'h00, 32'h0);
    check("ovf irq", {31'h0, bus.led_irq}, 32'h1);
    rd(8'h02, 32'd1, "ovf drops");
    rd(8'h01, 32'd16, "ovf seq");
    rd(8'h00, 32'h510, "ovf status");
    cycle(1'b1, mk_ev(DEPTH + 1), 1'b1, LED_REG_OVFCLR, 32'h1);
    check("drop beats w1c irq", {31'h0, bus.led_irq}, 32'h1);
    rd(8'h02, 32'd2, "drop2 drops");
    cycle(1'b0, '0, 1'b1, LED_REG_OVFCLR, 32'h1);
    check("w1c irq", {31'h0, bus.led_irq}, 32'h0);
    cycle(1'b1, mk_ev(DEPTH + 2), 1'b1, LED_REG_POP, 32'h0);
    check("full push+pop full", {31'h0, bus.led_full}, 32'h1);
    rd(8'h00, 32'h110, "full push+pop status");
    rd(8'h02, 32'd2,   "full push+pop drops");
    rd(8'h01, 32'd17,  "full push+pop seq");
    rd(8'h08, 32'd9,   "new head word0");
    rd(8'h0F, 32'd16,  "new head word7");

    // ---- reset with traffic, pop on empty, seed vs append ----
    for (int i = 0; i < 3; i++) cycle(1'b1, mk_ev(40 + i), 1'b0, 8'h00, 32'h0);
    do_reset(1'b1);
    rd(8'h00, 32'h200, "post-reset status");
    rd(8'h01, 32'h0,   "post-reset seq");
    rd(8'h03, 32'h0,   "post-reset chain");
    cycle(1'b0, '0, 1'b1, LED_REG_POP, 32'hFFFF_FFFF);
    rd(8'h00, 32'h200, "empty pop status");
    rd(8'h01, 32'h0,   "empty pop seq");
    rd(8'h02, 32'h0,   "empty pop drops");
    rd(8'h0F, 32'h0,   "empty head word7");
    cycle(1'b0, '0, 1'b1, LED_REG_SEED, 32'hDEAD_BEEF);
    rd(8'h03, 32'hDEAD_BEEF, "seed chain");
    cycle(1'b1, {224'h0, 32'h1}, 1'b1, LED_REG_SEED, 32'h1234_5678);
    rd(8'h03, 32'hD5B7_DDFA, "append beats seed chain");
    rd(8'h01, 32'h1,         "append beats seed seq");

    // ---- randomized run against the reference model ----
    do_reset(1'b0);
    m_q.delete();
    m_seq = 32'h0; m_drops = 32'h0; m_chain = 32'h0; m_ovf = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      push_heavy = ((i / 400) % 2) == 0;
      wr = ($urandom_range(0, 99) < (push_heavy ? 75 : 30));
      for (int k = 0; k < EV_WORDS; k++) ev[32*k +: 32] = $urandom();
      wdata = $urandom();
      we    = 1'b0;
      if ($urandom_range(0, 99) < (push_heavy ? 15 : 60)) begin
        addr = LED_REG_POP;
        we   = 1'b1;
      end else begin
        case ($urandom_range(0, 5))
          0, 1: addr = 8'($urandom_range(0, 3));
          2:    addr = 8'(8 + $urandom_range(0, 7));
          3:    begin addr = LED_REG_OVFCLR; we = 1'b1; end
          4:    begin addr = LED_REG_SEED;   we = 1'($urandom_range(0, 1)); end
          default: begin addr = 8'($urandom()); we = 1'($urandom_range(0, 1)); end
        endcase
      end
      exp_rd = m_read(addr);
      m_step(wr, ev, we, addr, wdata);
      cycle(wr, ev, we, addr, wdata);
      check($sformatf("rand%0d rdata@%02h", i, addr), bus.mmio_rdata, exp_rd);
      check($sformatf("rand%0d full", i), {31'h0, bus.led_full}, {31'h0, m_q.size() == DEPTH});
      check($sformatf("rand%0d irq", i),  {31'h0, bus.led_irq},  {31'h0, m_ovf});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
